// File: rtl/ser_par_pkg.sv
// rtl/ser_par_pkg.sv - shared types and constants for the serial/parallel stages
package ser_par_pkg;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-order encoding shared with the par-to-ser transmitter.
  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/ser_to_par_word_rx.sv
// rtl/ser_to_par_word_rx.sv - serial-to-parallel word receiver with one-entry holding register
module ser_to_par_word_rx
  import ser_par_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ser_in,
  input  logic             bit_valid_in,
  input  logic             start_in,
  input  logic             msb_first_in,
  input  logic             par_ready_in,
  input  logic             clr_err_in,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  rx_state_t        state;
  rx_state_t        next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             latched_msb;
  logic             order;
  logic             shift_en;
  logic             word_done;
  logic             resync_err;
  logic             take_word;

  // A start_in edge counts as bit 0 of a fresh word, using the newly requested order.
  always_comb begin
    order      = start_in ? msb_first_in : latched_msb;
    cnt_base   = start_in ? '0 : bit_cnt;
    shift_en   = bit_valid_in && (start_in || (state == SHIFT));
    shifted    = order ? {shift_reg[WIDTH-2:0], ser_in}
                       : {ser_in, shift_reg[WIDTH-1:1]};
    word_done  = shift_en && (cnt_base == CNT_W'(WIDTH-1));
    next_state = start_in ? SHIFT : state;
    cnt_next   = cnt_base;
    if (shift_en) begin
      cnt_next = word_done ? '0 : cnt_base + 1'b1;
    end
    resync_err = start_in && (state == SHIFT) && (bit_cnt != '0);
    take_word  = word_done && (!par_valid || par_ready_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      latched_msb <= MSB_FIRST;
      par_out     <= '0;
      par_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state   <= next_state;
      bit_cnt <= cnt_next;
      if (start_in) begin
        latched_msb <= msb_first_in;
      end
      if (shift_en) begin
        shift_reg <= shifted;
      end

      if (take_word) begin
        par_out   <= shifted;
        par_valid <= 1'b1;
      end else if (par_valid && par_ready_in) begin
        par_valid <= 1'b0;
      end

      // Error sets take priority over a coincident clear.
      if (word_done && par_valid && !par_ready_in) begin
        overrun <= 1'b1;
      end else if (clr_err_in) begin
        overrun <= 1'b0;
      end
      if (resync_err) begin
        frame_err <= 1'b1;
      end else if (clr_err_in) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_ser_to_par_word_rx.sv
// tb/tb_ser_to_par_word_rx.sv - self-checking bench for ser_to_par_word_rx
module tb_ser_to_par_word_rx;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         ser_in;
  logic         bit_valid_in;
  logic         start_in;
  logic         msb_first_in;
  logic         par_ready_in;
  logic         clr_err_in;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         overrun;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ser_to_par_word_rx #(.WIDTH(W)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .ser_in      (ser_in),
    .bit_valid_in(bit_valid_in),
    .start_in    (start_in),
    .msb_first_in(msb_first_in),
    .par_ready_in(par_ready_in),
    .clr_err_in  (clr_err_in),
    .par_out     (par_out),
    .par_valid   (par_valid),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collects the bits of the current word in arrival order and
  // weights them by position once W have been seen.
  logic         m_in_frame;
  logic         m_msb;
  int           m_cnt;
  logic         m_bits[W];
  logic [W-1:0] m_pout;
  logic         m_pv;
  logic         m_ovr;
  logic         m_fe;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_in_frame = 1'b0;
      m_msb      = 1'b1;
      m_cnt      = 0;
      m_pout     = '0;
      m_pv       = 1'b0;
      m_ovr      = 1'b0;
      m_fe       = 1'b0;
    end else begin
      logic         done;
      logic [W-1:0] word;
      done = 1'b0;
      word = '0;
      if (clr_err_in) begin
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end
      if (start_in) begin
        if (m_in_frame && m_cnt != 0) m_fe = 1'b1;
        m_cnt      = 0;
        m_msb      = msb_first_in;
        m_in_frame = 1'b1;
      end
      if (m_in_frame && bit_valid_in) begin
        m_bits[m_cnt] = ser_in;
        m_cnt++;
        if (m_cnt == W) begin
          for (int i = 0; i < W; i++) begin
            if (m_bits[i]) word = word + (m_msb ? (W'(1) << (W - 1 - i)) : (W'(1) << i));
          end
          m_cnt = 0;
          done  = 1'b1;
        end
      end
      if (done) begin
        if (!m_pv || par_ready_in) begin
          m_pout = word;
          m_pv   = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_pv && par_ready_in) begin
        m_pv = 1'b0;
      end
    end
  end

  always @(posedge clk_in) begin
    #1;
    chk("mdl_par_valid", {31'b0, par_valid}, {31'b0, m_pv});
    chk("mdl_par_out",   {24'b0, par_out},   {24'b0, m_pout});
    chk("mdl_overrun",   {31'b0, overrun},   {31'b0, m_ovr});
    chk("mdl_frame_err", {31'b0, frame_err}, {31'b0, m_fe});
    chk("mdl_busy",      {31'b0, busy},      {31'b0, m_in_frame});
  end

  task automatic cyc(input logic st, input logic msb, input logic bv, input logic sd,
                     input logic rdy, input logic clr);
    @(negedge clk_in);
    start_in     = st;
    msb_first_in = msb;
    bit_valid_in = bv;
    ser_in       = sd;
    par_ready_in = rdy;
    clr_err_in   = clr;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic msb, input logic rdy);
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, 1'b0, 1'b1, msb ? v[W-1-i] : v[i], rdy, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n_in = 1'b1;
  endtask

  logic [W-1:0] pattern;
  int           pulses;
  int           pulse_at[$];

  initial begin
    rst_n_in = 1'b0;
    {ser_in, bit_valid_in, start_in, msb_first_in, par_ready_in, clr_err_in} = '0;
    do_reset();
    #1;
    chk("rst_par_valid", {31'b0, par_valid}, 32'd0);
    chk("rst_par_out",   {24'b0, par_out},   32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);

    // MSB-first 0,0,0,1,1,1,1,0 -> 0x1E, one-cycle valid pulse
    pattern = 8'b0001_1110;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b0, 1'b1, pattern[W-1-i], 1'b1, 1'b0);
    chk("msb_valid_early", {31'b0, par_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("msb_valid", {31'b0, par_valid}, 32'd1);
    chk("msb_word",  {24'b0, par_out},   32'h1E);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("msb_valid_drop", {31'b0, par_valid}, 32'd0);

    // Same stream LSB-first -> 0x78
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b0, 1'b1, pattern[W-1-i], 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lsb_word", {24'b0, par_out}, 32'h78);

    // Loopback of 0xC3 serialised in each order
    for (int o = 0; o < 2; o++) begin
      cyc(1'b1, 1'(o), 1'b0, 1'b0, 1'b1, 1'b0);
      send_word(8'hC3, 1'(o), 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("loop_word", {24'b0, par_out}, 32'hC3);
    end

    // Overrun: 0x11 then 0x22 with the consumer stalled
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h11, 1'b1, 1'b0);
    send_word(8'h22, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_word", {24'b0, par_out}, 32'h11);
    chk("ovr_flag", {31'b0, overrun}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drained", {31'b0, par_valid}, 32'd0);
    chk("ovr_sticky",  {31'b0, overrun},   32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_cleared", {31'b0, overrun}, 32'd0);

    // Re-sync after 3 bits; new word 0x55 counted from the start_in bit
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    pattern = 8'h55;
    cyc(1'b1, 1'b1, 1'b1, pattern[7], 1'b1, 1'b0);
    for (int i = 1; i < W; i++) begin
      cyc(1'b0, 1'b0, 1'b1, pattern[W-1-i], 1'b1, 1'b0);
      if (i == 1) chk("fe_flag", {31'b0, frame_err}, 32'd1);
      if (i == W - 1) chk("fe_not_yet", {31'b0, par_valid}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fe_valid", {31'b0, par_valid}, 32'd1);
    chk("fe_word",  {24'b0, par_out},   32'h55);

    // IDLE ignores bit_valid_in, then async reset mid-word with a word held
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", {31'b0, par_valid}, 32'd0);
    chk("idle_busy",  {31'b0, busy},      32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'b0, par_valid}, 32'd1);
    chk("pre_rst_busy",  {31'b0, busy},      32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_valid", {31'b0, par_valid}, 32'd0);
    chk("arst_word",  {24'b0, par_out},   32'd0);
    chk("arst_busy",  {31'b0, busy},      32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n_in = 1'b1;

    // 24 continuous bits -> three pulses 8 cycles apart, no overrun
    pulses = 0;
    for (int k = 0; k < 26; k++) begin
      cyc(k == 0, 1'b1, k < 24, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (par_valid) begin
        pulses++;
        pulse_at.push_back(k);
      end
    end
    chk("stream_pulses", pulses, 3);
    if (pulse_at.size() == 3) begin
      chk("stream_p0", pulse_at[0], 8);
      chk("stream_gap1", pulse_at[1] - pulse_at[0], 8);
      chk("stream_gap2", pulse_at[2] - pulse_at[1], 8);
    end
    chk("stream_ovr", {31'b0, overrun}, 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_to_par_word_rx.md
Name: ser_to_par_word_rx

Overview:
- Serial-to-parallel receive stage. It sits directly downstream of the par-to-ser shift register and consumes its ser_out stream.
- Reassembles WIDTH-bit words in either MSB-first or LSB-first order, selected per frame.
- Presents each word on a one-entry valid/ready output holding register.
- Flags overrun (word lost because the holding register is full) and frame error (re-sync mid-word).

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk_in  input  1  rising-edge clock.
- rst_n_in  input  1  asynchronous active-low reset.
- ser_in  input  1  serial data bit.
- bit_valid_in  input  1  ser_in is sampled on this edge.
- start_in  input  1  frame sync: restart word alignment and latch msb_first_in.
- msb_first_in  input  1  bit order for the frame; 1 = MSB first. Sampled only with start_in.
- par_ready_in  input  1  consumer accepts par_out this cycle.
- clr_err_in  input  1  clears overrun and frame_err.
- par_out  output  WIDTH  assembled word (holding register).
- par_valid  output  1  par_out holds an unconsumed word.
- overrun  output  1  sticky: completed word dropped.
- frame_err  output  1  sticky: start_in arrived with a partial word pending.
- busy  output  1  state == SHIFT.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous, active-low (rst_n_in). Reset deasserts synchronously externally.
- Reset values:
  - state = IDLE, shift_reg = 0, bit_cnt = 0, latched_msb = 1.
  - par_out = 0, par_valid = 0, overrun = 0, frame_err = 0, busy = 0.
  - Reset asserted mid-word or with par_valid high discards everything immediately.
- States:
  - IDLE: bit_valid_in is ignored.
  - SHIFT: receiving. IDLE->SHIFT on start_in. SHIFT has no exit other than reset; start_in in SHIFT re-syncs.
- start_in edge:
  - bit_cnt <= 0; latched_msb <= msb_first_in; shift_reg unchanged.
  - If bit_valid_in is high on the same edge, that bit is bit 0 of the new word: it is shifted using the new order and bit_cnt <= 1.
  - In SHIFT with bit_cnt != 0: partial word discarded, frame_err <= 1.
- Shift rule on each bit_valid_in in SHIFT:
  - latched_msb = 1: shift_reg <= {shift_reg[WIDTH-2:0], ser_in}.
  - latched_msb = 0: shift_reg <= {ser_in, shift_reg[WIDTH-1:1]}.
  - bit_cnt increments.
- Word completion:
  - Occurs on a bit_valid_in edge with bit_cnt == WIDTH-1. bit_cnt wraps to 0 and the state stays SHIFT (back-to-back words).
  - The completed word (including the current bit) is written to par_out and par_valid <= 1 on that same edge. par_valid is therefore visible the cycle after the last bit is sampled (latency 1).
- Holding register:
  - Handshake: transfer when par_valid && par_ready_in; par_valid <= 0 unless refilled on the same edge.
  - Completion with par_valid=0, or par_valid=1 && par_ready_in=1: par_out loads the new word, par_valid stays/goes 1, no overrun.
  - Completion with par_valid=1 && par_ready_in=0: the new word is dropped, par_out holds the old word, overrun <= 1.
  - par_out is stable while par_valid=1 && par_ready_in=0.
- Error flags:
  - overrun and frame_err are sticky and cleared only by clr_err_in or reset.
  - If clr_err_in coincides with a new error event, the set wins.
- par_ready_in is ignored when par_valid=0.
- No combinational path from any input to any output.

Decomposition:
- Package ser_par_pkg:
  - typedef enum logic {IDLE, SHIFT} rx_state_t.
  - localparam DEFAULT_WIDTH = 8.
  - Bit-order constants MSB_FIRST = 1'b1 and LSB_FIRST = 1'b0, shared with the par-to-ser stage.
- No sub-module. Single always_ff for state, counter, shift register and holding register. always_comb for next-state and completion decode.

Test Plan:
- Reset, then start_in with msb_first_in=1, then bits 0,0,0,1,1,1,1,0 on consecutive cycles, par_ready_in=1 -> par_out=0x1E, par_valid high for exactly one cycle, starting the cycle after the 8th bit.
- Same bit stream with msb_first_in=0 -> par_out=0x78. Also loop back from the par-to-ser stage loaded with 0xC3 in each order -> par_out=0xC3 both times.
- par_ready_in=0, two full words 0x11 then 0x22 -> par_out stays 0x11, overrun=1. Then par_ready_in=1 for one cycle -> par_valid=0. Then clr_err_in -> overrun=0.
- 3 bits received, then start_in together with bit_valid_in, then 7 more bits -> frame_err=1, and the word completes after 8 bits counted from the start_in bit.
- bit_valid_in pulses while in IDLE -> no shift, par_valid stays 0, busy=0. rst_n_in low after 5 bits in SHIFT -> all outputs 0 asynchronously, with no clock edge needed.
- Continuous bit_valid_in for 24 cycles with par_ready_in=1 -> three par_valid pulses spaced 8 cycles apart, and no overrun.
